// File: rtl/calculator_pkg.sv
// Shared widths and types for the calculator datapath.
// The result packer folds two adder sums into one memory word.
package calculator_pkg;

    localparam int DATA_W        = 32;
    localparam int MEM_WORD_SIZE = 64;

    // Which half of the memory word the next accepted sum will fill.
    typedef enum logic {
        PK_LOWER = 1'b0,
        PK_UPPER = 1'b1
    } pack_state_t;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry first-in first-out buffer with push, pop, full, empty and count.
// It accepts a push while full only when a pop happens in the same cycle.
module word_fifo2 #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // When full, the write slot is the read slot; the pop reads the old
    // contents this cycle, so overwriting it at the edge keeps order intact.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/result_packer.sv
// Packs pairs of 32-bit sums into 64-bit memory words {upper, lower},
// buffering up to two finished words and supporting a zero-padded flush.
module result_packer
    import calculator_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     flush_i,
    output logic                     out_valid,
    output logic [MEM_WORD_SIZE-1:0] out_data,
    input  logic                     out_ready,
    output logic                     half_o,
    output logic [1:0]               count_o,
    output logic                     empty_o
);

    pack_state_t              state_q, state_d;
    logic [DATA_W-1:0]        lower_q, lower_d;
    logic                     accept;
    logic                     has_space;
    logic                     flush_push;
    logic                     push;
    logic                     pop;
    logic [MEM_WORD_SIZE-1:0] push_data;
    logic                     fifo_full;
    logic                     fifo_empty;

    assign half_o    = (state_q == PK_UPPER);
    assign out_valid = !fifo_empty;
    assign empty_o   = fifo_empty && !half_o;
    assign pop       = out_valid && out_ready;

    // A pop in the same cycle frees the slot a completed word needs.
    always_comb begin
        has_space  = !fifo_full || out_ready;
        in_ready   = !half_o || has_space;
        accept     = in_valid && in_ready;
        flush_push = half_o && flush_i && !accept && has_space;
        push       = (half_o && accept) || flush_push;
        push_data  = accept ? {in_data, lower_q} : {{DATA_W{1'b0}}, lower_q};
        state_d    = state_q;
        lower_d    = lower_q;
        unique case (state_q)
            PK_LOWER: begin
                if (accept) begin
                    lower_d = in_data;
                    state_d = PK_UPPER;
                end
            end
            PK_UPPER: begin
                if (push) begin
                    state_d = PK_LOWER;
                end
            end
            default: state_d = PK_LOWER;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= PK_LOWER;
            lower_q <= '0;
        end else begin
            state_q <= state_d;
            lower_q <= lower_d;
        end
    end

    word_fifo2 #(
        .WIDTH(MEM_WORD_SIZE)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

endmodule

// File: tb/tb_result_packer.sv
// Directed, table-driven bench for result_packer: each row gives the inputs
// for one cycle and the outputs expected just before the next rising edge.
module tb_result_packer;
    import calculator_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    logic                     in_valid = 1'b0;
    logic [DATA_W-1:0]        in_data = '0;
    logic                     in_ready;
    logic                     flush_i = 1'b0;
    logic                     out_valid;
    logic [MEM_WORD_SIZE-1:0] out_data;
    logic                     out_ready = 1'b0;
    logic                     half_o;
    logic [1:0]               count_o;
    logic                     empty_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        fl;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [63:0] e_od;
        logic        e_half;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    always #5 clk_i = ~clk_i;

    result_packer dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush_i   (flush_i),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .half_o    (half_o),
        .count_o   (count_o),
        .empty_o   (empty_o)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] d, input logic fl, input logic ordy);
        in_valid  = v;
        in_data   = d;
        flush_i   = fl;
        out_ready = ordy;
    endtask

    task automatic add(input logic v, input logic [31:0] d, input logic fl, input logic ordy,
                       input logic ir, input logic ov, input logic [63:0] od,
                       input logic h, input logic [1:0] c);
        vec_t r;
        r.v = v; r.d = d; r.fl = fl; r.ordy = ordy;
        r.e_ir = ir; r.e_ov = ov; r.e_od = od; r.e_half = h; r.e_cnt = c;
        vecs.push_back(r);
    endtask

    task automatic check_idle_reset(input string tag);
        check_output({tag, " out_valid"}, 64'(out_valid), 64'd0);
        check_output({tag, " out_data"},  out_data,       64'd0);
        check_output({tag, " half"},      64'(half_o),    64'd0);
        check_output({tag, " count"},     64'(count_o),   64'd0);
        check_output({tag, " empty"},     64'(empty_o),   64'd1);
        check_output({tag, " in_ready"},  64'(in_ready),  64'd1);
    endtask

    initial begin
        // basic pack
        add(1, 32'h11111111, 0, 1,  1, 0, 64'h0, 0, 0);
        add(1, 32'h22222222, 0, 1,  1, 0, 64'h0, 1, 0);
        add(0, 32'h0,        0, 1,  1, 1, 64'h22222222_11111111, 0, 1);
        add(0, 32'h0,        0, 0,  1, 0, 64'h0, 0, 0);
        // backpressure with six beats, then release
        add(1, 32'd1, 0, 0,  1, 0, 64'h0, 0, 0);
        add(1, 32'd2, 0, 0,  1, 0, 64'h0, 1, 0);
        add(1, 32'd3, 0, 0,  1, 1, {32'd2, 32'd1}, 0, 1);
        add(1, 32'd4, 0, 0,  1, 1, {32'd2, 32'd1}, 1, 1);
        add(1, 32'd5, 0, 0,  1, 1, {32'd2, 32'd1}, 0, 2);
        add(1, 32'd6, 0, 0,  0, 1, {32'd2, 32'd1}, 1, 2);
        add(1, 32'd6, 0, 1,  1, 1, {32'd2, 32'd1}, 1, 2);
        add(0, 32'd0, 0, 1,  1, 1, {32'd4, 32'd3}, 0, 2);
        add(0, 32'd0, 0, 1,  1, 1, {32'd6, 32'd5}, 0, 1);
        add(0, 32'd0, 0, 0,  1, 0, 64'h0, 0, 0);
        // flush pads, flush in lower half does nothing
        add(1, 32'hDEADBEEF, 0, 0,  1, 0, 64'h0, 0, 0);
        add(0, 32'h0,        1, 0,  1, 0, 64'h0, 1, 0);
        add(0, 32'h0,        1, 0,  1, 1, 64'h00000000_DEADBEEF, 0, 1);
        add(0, 32'h0,        0, 1,  1, 1, 64'h00000000_DEADBEEF, 0, 1);
        add(0, 32'h0,        0, 0,  1, 0, 64'h0, 0, 0);
        // flush together with a beat
        add(1, 32'hAAAA0001, 0, 0,  1, 0, 64'h0, 0, 0);
        add(1, 32'h00000005, 1, 0,  1, 0, 64'h0, 1, 0);
        add(0, 32'h0,        0, 1,  1, 1, 64'h00000005_AAAA0001, 0, 1);
        add(0, 32'h0,        0, 0,  1, 0, 64'h0, 0, 0);
        // flush with a full buffer waits for space
        add(1, 32'hA1, 0, 0,  1, 0, 64'h0, 0, 0);
        add(1, 32'hA2, 0, 0,  1, 0, 64'h0, 1, 0);
        add(1, 32'hB1, 0, 0,  1, 1, {32'hA2, 32'hA1}, 0, 1);
        add(1, 32'hB2, 0, 0,  1, 1, {32'hA2, 32'hA1}, 1, 1);
        add(1, 32'hC1, 0, 0,  1, 1, {32'hA2, 32'hA1}, 0, 2);
        add(0, 32'h0,  1, 0,  0, 1, {32'hA2, 32'hA1}, 1, 2);
        add(0, 32'h0,  1, 1,  1, 1, {32'hA2, 32'hA1}, 1, 2);
        add(0, 32'h0,  0, 1,  1, 1, {32'hB2, 32'hB1}, 0, 2);
        add(0, 32'h0,  0, 1,  1, 1, {32'h0,  32'hC1}, 0, 1);
        add(0, 32'h0,  0, 0,  1, 0, 64'h0, 0, 0);

        #3;
        check_idle_reset("reset");
        @(posedge clk_i); #1;
        check_idle_reset("reset held");
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].v, vecs[i].d, vecs[i].fl, vecs[i].ordy);
            @(negedge clk_i);
            check_output($sformatf("row%0d in_ready", i),  64'(in_ready),  64'(vecs[i].e_ir));
            check_output($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            if (vecs[i].e_ov)
                check_output($sformatf("row%0d out_data", i), out_data, vecs[i].e_od);
            check_output($sformatf("row%0d half", i),  64'(half_o),  64'(vecs[i].e_half));
            check_output($sformatf("row%0d count", i), 64'(count_o), 64'(vecs[i].e_cnt));
            check_output($sformatf("row%0d empty", i), 64'(empty_o),
                         64'(vecs[i].e_cnt == 2'd0 && !vecs[i].e_half));
            @(posedge clk_i); #1;
        end

        // asynchronous reset with a full buffer and a pending lower half
        for (int b = 1; b <= 5; b++) begin
            apply_stimulus(1'b1, 32'(b), 1'b0, 1'b0);
            @(posedge clk_i); #1;
        end
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk_i);
        check_output("pre-reset count", 64'(count_o), 64'd2);
        check_output("pre-reset half",  64'(half_o),  64'd1);
        #2 rst_i = 1'b1;
        #1;
        check_idle_reset("async reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        apply_stimulus(1'b1, 32'h77, 1'b0, 1'b1);
        @(posedge clk_i); #1;
        apply_stimulus(1'b1, 32'h88, 1'b0, 1'b1);
        @(posedge clk_i); #1;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        check_output("post-reset out_valid", 64'(out_valid), 64'd1);
        check_output("post-reset out_data",  out_data, {32'h88, 32'h77});
        check_output("post-reset count",     64'(count_o), 64'd1);
        @(posedge clk_i); #1;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk_i);
        check_output("post-reset drained", 64'(out_valid), 64'd0);
        check_output("post-reset empty",   64'(empty_o),   64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
